// File: rtl/tb_vector_sequencer.sv
// Exhaustive handshaked stimulus sweeper with rotating-XOR response signature.
// Optional LFSR order (mode 3) built only when TBGEN_LFSR_MODE_EN is defined.
module tb_vector_sequencer #(
  parameter int WIDTH = 5,
  parameter int HOLD  = 1,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  input  logic             vec_ready,
  input  logic [OUT_W-1:0] resp_in,
  output logic [WIDTH-1:0] vec_index,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] resp_sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [WIDTH-1:0] LAST = '1;

`ifdef TBGEN_LFSR_MODE_EN
  localparam logic [7:0] TAPS8 =
    (WIDTH == 2) ? 8'h03 :
    (WIDTH == 3) ? 8'h06 :
    (WIDTH == 4) ? 8'h0C :
    (WIDTH == 5) ? 8'h14 :
    (WIDTH == 6) ? 8'h30 :
    (WIDTH == 7) ? 8'h60 : 8'hB8;
  localparam logic [WIDTH-1:0] TAPS = TAPS8[WIDTH-1:0];
`endif

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;

  logic             load;
  logic [1:0]       msel;
  logic [WIDTH-1:0] nidx;
  logic [WIDTH-1:0] nvec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      sig_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    hcnt_d  = hcnt_q;
    load    = 1'b0;
    msel    = mode_q;
    nidx    = idx_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          mode_d  = mode;
          msel    = mode;
          idx_d   = '0;
          nidx    = '0;
          sig_d   = '0;
          load    = 1'b1;
        end
      end
      S_DRIVE: begin
        if (vec_ready) begin
          state_d = S_HOLD;
          hcnt_d  = HCW'(HOLD - 1);
        end
      end
      S_HOLD: begin
        if (hcnt_q == '0) begin
          sig_d = {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ resp_in;
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
            idx_d   = idx_q + 1'b1;
            nidx    = idx_q + 1'b1;
            load    = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next vector; in LFSR order the current vector is the register state.
  always_comb begin
    nvec = nidx;
    unique case (1'b1)
      (msel == 2'd1): nvec = nidx ^ (nidx >> 1);
      (msel == 2'd2): nvec = ~nidx;
`ifdef TBGEN_LFSR_MODE_EN
      (msel == 2'd3): begin
        if (nidx == '0)
          nvec = '0;
        else if (nidx == WIDTH'(1))
          nvec = WIDTH'(1);
        else
          nvec = {vec_q[WIDTH-2:0], ^(vec_q & TAPS)};
      end
`endif
      default: nvec = nidx;
    endcase
    vec_d = load ? nvec : vec_q;
  end

  assign vec_out   = vec_q;
  assign vec_valid = (state_q == S_DRIVE);
  assign busy      = (state_q == S_DRIVE) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);
  assign vec_index = idx_q;
  assign resp_sig  = sig_q;

endmodule

// File: doc/tb_vector_sequencer.md
Name: tb_vector_sequencer

Overview:
- Synthesizable exhaustive stimulus engine for combinational DUT checking. Sweeps every 2^WIDTH input vector into the DUT in a selectable order, holds each vector for HOLD settle cycles, and samples the DUT response.
- Compresses all responses into a rotating-XOR signature for pass/fail comparison.
- Sits between the bench top and the DUT. Replaces hand-unrolled vector lists with one reusable, handshaked generator.

Parameters:
- WIDTH, 5, stimulus vector width; legal range 2..8.
- HOLD, 1, settle cycles per vector after acceptance; legal range >=1.
- OUT_W, 8, DUT response width and signature width; legal range >=2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE or DONE.
- mode  in  2  order select, latched on start: 0 binary up, 1 Gray, 2 binary down, 3 LFSR (see Optional Feature).
- vec_out  out  WIDTH  current stimulus vector.
- vec_valid  out  1  vec_out offered to DUT.
- vec_ready  in  1  DUT/bench accepts vec_out.
- resp_in  in  OUT_W  DUT response.
- vec_index  out  WIDTH  sweep position, 0..2^WIDTH-1.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; level signal.
- resp_sig  out  OUT_W  response signature.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. vec_out, vec_index, resp_sig = 0. vec_valid, busy, done = 0.
- States and transitions:
  - IDLE: on start -> DRIVE. Latch mode, clear vec_index and resp_sig, clear done, set busy.
  - DRIVE: vec_valid=1, vec_out=map(vec_index). On vec_valid & vec_ready -> HOLD with hold_cnt=HOLD-1. While vec_ready=0, stay in DRIVE with vec_out stable.
  - HOLD: vec_valid=0, vec_out stable. hold_cnt decrements each cycle. When hold_cnt==0, sample resp_in:
    - resp_sig <= {resp_sig[OUT_W-2:0], resp_sig[OUT_W-1]} ^ resp_in.
    - If vec_index==2^WIDTH-1 -> DONE; else vec_index++ -> DRIVE.
  - DONE: busy=0, done=1, vec_out holds the last vector. start -> DRIVE, with the same clears as in IDLE.
- Vector maps:
  - Binary up: vec_index.
  - Gray: vec_index ^ (vec_index>>1).
  - Binary down: ~vec_index.
- Latency:
  - vec_valid rises the cycle after start is sampled.
  - With vec_ready tied high, each vector takes 1+HOLD cycles; a full sweep takes 2^WIDTH*(1+HOLD) cycles.
  - done rises the cycle after the final sample.
- Boundary conditions:
  - vec_index never wraps; the terminal compare ends the sweep.
  - start during DRIVE/HOLD is ignored; mode changes mid-sweep are ignored.
  - vec_ready asserted during HOLD is ignored.
  - Reset mid-sweep returns immediately to reset values; no partial signature is retained.

Optional Feature:
- Macro TBGEN_LFSR_MODE_EN.
- Defined: mode 3 emits vector 0 at index 0, then a maximal-length Fibonacci LFSR seeded to 1, advancing one step per accepted vector. This covers all 2^WIDTH vectors exactly once.
  - Fixed XNOR-free taps per WIDTH: 2:{1,0} 3:{2,1} 4:{3,2} 5:{4,2} 6:{5,4} 7:{6,5} 8:{7,5,4,3}.
- Undefined: no LFSR logic is built, and mode 3 behaves as binary up.

Test Plan:
- WIDTH=3, HOLD=1, mode=0, vec_ready=1, start pulse -> vec_out accepted in order 0..7, one every 2 cycles; done=1 at cycle 17 after start; busy is 0 at the same time.
- WIDTH=3, mode=1 -> accepted sequence 0,1,3,2,6,7,5,4. With mode=2 -> 7,6,5,4,3,2,1,0.
- OUT_W=4, resp_in=4'h1 only while vector 0 is sampled, else 0 -> final resp_sig=4'h8. With resp_in=4'h1 on every vector -> resp_sig=4'h0.
- Backpressure: vec_ready=0 for 5 cycles on vector 3 -> vec_valid=1 and vec_out=3 stable throughout; no index advance; the sweep otherwise completes unchanged.
- Reset asserted mid-HOLD at vec_index=4 -> all outputs return to 0 asynchronously. After release, the next start restarts at vector 0. start pulsed during busy has no effect.
- With TBGEN_LFSR_MODE_EN, WIDTH=3, mode=3 -> eight distinct vectors starting 0,1; done after 8 accepts. Without the macro, mode=3 -> 0..7 in order.
